edge_detect_bank: RTL and testbench

//  Multi-channel input conditioner for button and switch inputs. Each channel is

---
 rtl/edge_detect_bank.sv | 146 ++++++++++++++
 tb/tb_edge_detect_bank.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_bank.sv
// Multi-channel input conditioner: per-channel synchroniser, debouncer and
// edge/auto-repeat pulse generator for buttons and switches.
module edge_detect_bank #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  output logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     pulse
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam bit REP_EN = (REPEAT_DELAY > 0);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [WIDTH-1:0] sync_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_s = in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_r [SYNC_STAGES];

      // Shift the raw inputs through the synchroniser chain
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= {WIDTH{1'b0}};
          end
        end else begin
          sync_r[0] <= in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
          end
        end
      end

      assign sync_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CW-1:0] cnt_r, cnt_nxt_s;
      logic          level_r, level_nxt_s;
      logic          pulse_r, pulse_nxt_s;
      logic          rise_s, fall_s;
      logic          rise_en_s, fall_en_s;
      logic          rep_act_r, rep_act_nxt_s;
      logic          rep_first_r, rep_first_nxt_s;
      logic [RW-1:0] rep_cnt_r, rep_cnt_nxt_s;
      logic          rep_hit_s;

      assign rise_en_s = mode[2*i];
      assign fall_en_s = mode[2*i+1];

      // Debounce: accept a new level only after it persists DEBOUNCE_CYCLES edges
      always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        if (sync_s[i] != level_r) begin
          if (cnt_r == DB_LAST) begin
            level_nxt_s = sync_s[i];
            cnt_nxt_s   = {CW{1'b0}};
            rise_s      = sync_s[i];
            fall_s      = ~sync_s[i];
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_nxt_s = {CW{1'b0}};
        end
      end

      // Auto-repeat timer: armed by a rise pulse, first slot after the delay, then periodic
      always_comb begin
        rep_act_nxt_s   = rep_act_r;
        rep_first_nxt_s = rep_first_r;
        rep_cnt_nxt_s   = rep_cnt_r;
        rep_hit_s       = 1'b0;
        if (!REP_EN || !rise_en_s || fall_s) begin
          rep_act_nxt_s   = 1'b0;
          rep_first_nxt_s = 1'b1;
          rep_cnt_nxt_s   = {RW{1'b0}};
        end else if (rise_s) begin
          rep_act_nxt_s   = 1'b1;
          rep_first_nxt_s = 1'b1;
          rep_cnt_nxt_s   = {RW{1'b0}};
        end else if (rep_act_r && level_r) begin
          if (rep_cnt_r == (rep_first_r ? RD_LAST : RP_LAST)) begin
            rep_hit_s       = 1'b1;
            rep_first_nxt_s = 1'b0;
            rep_cnt_nxt_s   = {RW{1'b0}};
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + RW'(1);
          end
        end else begin
          rep_act_nxt_s   = 1'b0;
          rep_first_nxt_s = 1'b1;
          rep_cnt_nxt_s   = {RW{1'b0}};
        end
      end

      // Pulse on the edge where the new level is registered; a fall suppresses repeats
      always_comb begin
        pulse_nxt_s = (rise_s & rise_en_s) | (fall_s & fall_en_s) | rep_hit_s;
      end

      // Per-channel state registers
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_r       <= {CW{1'b0}};
          level_r     <= 1'b0;
          pulse_r     <= 1'b0;
          rep_act_r   <= 1'b0;
          rep_first_r <= 1'b1;
          rep_cnt_r   <= {RW{1'b0}};
        end else begin
          cnt_r       <= cnt_nxt_s;
          level_r     <= level_nxt_s;
          pulse_r     <= pulse_nxt_s;
          rep_act_r   <= rep_act_nxt_s;
          rep_first_r <= rep_first_nxt_s;
          rep_cnt_r   <= rep_cnt_nxt_s;
        end
      end

      assign level[i] = level_r;
      assign pulse[i] = pulse_r;
    end
  endgenerate

endmodule

// File: tb/tb_edge_detect_bank.sv
// Bench for edge_detect_bank: one default instance and one with auto-repeat,
// expected pulse vectors queued per cycle and compared every cycle.
module tb_edge_detect_bank;

  localparam int LAT = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_a, in_b;
  logic [7:0] mode_a, mode_b;
  logic [3:0] level_a, pulse_a, level_b, pulse_b;

  always #5 clk = ~clk;

  edge_detect_bank #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16),
                     .REPEAT_DELAY(0), .REPEAT_PERIOD(8)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .mode(mode_a), .level(level_a), .pulse(pulse_a));

  edge_detect_bank #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16),
                     .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .mode(mode_b), .level(level_b), .pulse(pulse_b));

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  // Insert an expected pulse vector, merging channels that fire in the same cycle
  task automatic push_ev(input bit to_b, input int c, input logic [3:0] m);
    ev_t q[$];
    ev_t e;
    bit  done;
    done = 1'b0;
    if (to_b) q = qb; else q = qa;
    for (int k = 0; k < q.size() && !done; k++) begin
      if (q[k].cyc == c) begin
        q[k].mask = q[k].mask | m;
        done = 1'b1;
      end else if (q[k].cyc > c) begin
        e.cyc = c; e.mask = m;
        q.insert(k, e);
        done = 1'b1;
      end
    end
    if (!done) begin
      e.cyc = c; e.mask = m;
      q.push_back(e);
    end
    if (to_b) qb = q; else qa = q;
  endtask

  // One clock; pop this cycle's expectation (or zero) and compare both pulse buses
  task automatic tick();
    logic [3:0] ea, eb;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    ea = 4'b0000;
    eb = 4'b0000;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin ea = qa[0].mask; qa.delete(0); end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin eb = qb[0].mask; qb.delete(0); end
    tests++;
    if (pulse_a !== ea) begin
      fails++;
      $display("FAIL pulse_a cyc=%0d got=%b exp=%b", cyc, pulse_a, ea);
    end
    tests++;
    if (pulse_b !== eb) begin
      fails++;
      $display("FAIL pulse_b cyc=%0d got=%b exp=%b", cyc, pulse_b, eb);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_a = 4'b0000; in_b = 4'b0000; mode_a = 8'h00; mode_b = 8'h00;
    ticks(3);
    tests++;
    if (level_a !== 4'b0000 || level_b !== 4'b0000) begin
      fails++;
      $display("FAIL reset_level got=%b/%b exp=0000/0000", level_a, level_b);
    end
    rst = 1'b0;
    ticks(4);
  endtask

  task automatic test_rise();
    int c;
    mode_a = 8'b0000_0001;
    c = cyc;
    in_a[0] = 1'b1;
    push_ev(1'b0, c + LAT, 4'b0001);
    wait_until(c + LAT - 1);
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL rise_early got=%b exp=0000", level_a);
    end
    tick();
    tests++;
    if (level_a !== 4'b0001) begin
      fails++; $display("FAIL rise_level got=%b exp=0001", level_a);
    end
    ticks(5);
    tests++;
    if (level_a !== 4'b0001) begin
      fails++; $display("FAIL rise_hold got=%b exp=0001", level_a);
    end
    in_a[0] = 1'b0;
    ticks(LAT + 4);
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL rise_release got=%b exp=0000", level_a);
    end
  endtask

  task automatic test_glitch();
    int c;
    mode_a = 8'b0000_1100;
    in_a[1] = 1'b1;
    ticks(15);
    in_a[1] = 1'b0;
    ticks(LAT + 10);
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL glitch15_level got=%b exp=0000", level_a);
    end
    // 16 cycles is just long enough: a rise, and the release is a fall (mode 11)
    c = cyc;
    in_a[1] = 1'b1;
    push_ev(1'b0, c + LAT, 4'b0010);
    ticks(16);
    in_a[1] = 1'b0;
    push_ev(1'b0, c + 16 + LAT, 4'b0010);
    wait_until(c + LAT);
    tests++;
    if (level_a !== 4'b0010) begin
      fails++; $display("FAIL glitch16_level got=%b exp=0010", level_a);
    end
    wait_until(c + 16 + LAT + 3);
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL glitch16_fall got=%b exp=0000", level_a);
    end
  endtask

  task automatic test_fall_only();
    int c;
    mode_a = 8'b0010_0000;
    c = cyc;
    in_a[2] = 1'b1;
    ticks(40);
    tests++;
    if (level_a !== 4'b0100) begin
      fails++; $display("FAIL fall_only_press got=%b exp=0100", level_a);
    end
    in_a[2] = 1'b0;
    push_ev(1'b0, c + 40 + LAT, 4'b0100);
    wait_until(c + 40 + LAT - 1);
    tests++;
    if (level_a !== 4'b0100) begin
      fails++; $display("FAIL fall_only_early got=%b exp=0100", level_a);
    end
    tick();
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL fall_only_level got=%b exp=0000", level_a);
    end
    ticks(5);
  endtask

  task automatic test_reset_hold();
    int c, r;
    mode_a = 8'b0101_0101;
    in_a   = 4'b1111;
    rst    = 1'b1;
    ticks(3);
    c = cyc;
    rst = 1'b0;
    push_ev(1'b0, c + LAT, 4'b1111);
    wait_until(c + LAT - 1);
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL hold_early got=%b exp=0000", level_a);
    end
    tick();
    tests++;
    if (level_a !== 4'b1111) begin
      fails++; $display("FAIL hold_level got=%b exp=1111", level_a);
    end
    ticks(10);
    r = cyc;
    rst = 1'b1;
    tick();
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL midhold_reset got=%b exp=0000", level_a);
    end
    rst = 1'b0;
    push_ev(1'b0, r + 1 + LAT, 4'b1111);
    wait_until(r + LAT);
    tests++;
    if (level_a !== 4'b0000) begin
      fails++; $display("FAIL rerise_early got=%b exp=0000", level_a);
    end
    tick();
    tests++;
    if (level_a !== 4'b1111) begin
      fails++; $display("FAIL rerise_level got=%b exp=1111", level_a);
    end
    in_a = 4'b0000;
    ticks(LAT + 3);
  endtask

  task automatic test_repeat();
    int c, t0;
    mode_b = 8'b0100_0000;
    c  = cyc;
    t0 = c + LAT;
    in_b[3] = 1'b1;
    push_ev(1'b1, t0, 4'b1000);
    for (int n = 0; n < 8; n++) push_ev(1'b1, t0 + 20 + 5 * n, 4'b1000);
    // release so that level falls exactly on the t0+60 repeat slot
    wait_until(t0 + 42);
    in_b[3] = 1'b0;
    wait_until(t0 + 59);
    tests++;
    if (level_b !== 4'b1000) begin
      fails++; $display("FAIL repeat_held got=%b exp=1000", level_b);
    end
    tick();
    tests++;
    if (level_b !== 4'b0000) begin
      fails++; $display("FAIL repeat_fall got=%b exp=0000", level_b);
    end
    ticks(20);
  endtask

  task automatic test_mode_off();
    int c, t0;
    mode_b = 8'b0000_0001;
    c  = cyc;
    t0 = c + LAT;
    in_b[0] = 1'b1;
    push_ev(1'b1, t0, 4'b0001);
    push_ev(1'b1, t0 + 20, 4'b0001);
    push_ev(1'b1, t0 + 25, 4'b0001);
    wait_until(t0 + 25);
    mode_b = 8'b0000_0000;
    ticks(20);
    tests++;
    if (level_b !== 4'b0001) begin
      fails++; $display("FAIL mode_off_level got=%b exp=0001", level_b);
    end
    in_b[0] = 1'b0;
    ticks(LAT + 3);
    tests++;
    if (level_b !== 4'b0000) begin
      fails++; $display("FAIL mode_off_release got=%b exp=0000", level_b);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_fall_only();
    test_reset_hold();
    test_repeat();
    test_mode_off();
    ticks(5);
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d/%0d pending exp=0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
